// File: rtl/lu_arb_pkg.sv
// Shared types and limits for the round-robin logic-unit arbiter.
// Used by rr_picker and lu_arbiter.
package lu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_MAX = 8;
    localparam int ID_W_MAX    = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first valid requester at or after ptr,
// searching upward with wrap-around, wins.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    win_idx,
    output logic               any_valid
);

    // Scan offsets from farthest to nearest so the closest valid requester wins last.
    always_comb begin
        int cand_s;
        cand_s    = 0;
        grant     = '0;
        win_idx   = '0;
        any_valid = |req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s = int'(ptr) + i;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (req_valid[ID_W'(cand_s)]) begin
                win_idx = ID_W'(cand_s);
            end else begin
                win_idx = win_idx;
            end
        end
        if (any_valid) begin
            grant[win_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter and sequencer sharing one 1-bit logic unit among NUM_REQ requesters.
// Optional grant statistics counter enabled by defining LU_ARB_STATS_EN.
module lu_arbiter
    import lu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_a,
    input  logic [NUM_REQ-1:0]         req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       lu_a,
    output logic                       lu_b,
    input  logic                       lu_y,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_y,
    output logic                       busy
`ifdef LU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]           grant_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || ID_W > ID_W_MAX || CNT_W < 1) begin : g_illegal_params
        $error("lu_arbiter: illegal parameter combination");
    end

    arb_state_e         state_r;
    arb_state_e         state_next_s;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic               lu_a_r;
    logic               lu_b_r;
    logic               rsp_y_r;
    logic               rsp_valid_r;
    logic               busy_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    win_idx_s;
    logic               any_valid_s;
    logic               accept_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [ID_W-1:0]    ptr_next_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .win_idx   (win_idx_s),
        .any_valid (any_valid_s)
    );

    // Next state and the accept strobe; requests are only taken in IDLE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        req_ready_s  = '0;
        case (state_r)
            IDLE: begin
                if (any_valid_s && !rst) begin
                    accept_s     = 1'b1;
                    req_ready_s  = grant_s;
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC:    state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Pointer moves one past the winner, wrapping at NUM_REQ.
    always_comb begin
        if (win_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_idx_s + ID_W'(1);
        end
    end

    // State register and busy flag, which mirrors "state is not IDLE".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Operand, owner and pointer capture on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r  <= '0;
            id_r   <= '0;
            lu_a_r <= 1'b0;
            lu_b_r <= 1'b0;
        end else if (accept_s) begin
            ptr_r  <= ptr_next_s;
            id_r   <= win_idx_s;
            lu_a_r <= req_a[win_idx_s];
            lu_b_r <= req_b[win_idx_s];
        end else begin
            ptr_r  <= ptr_r;
            id_r   <= id_r;
            lu_a_r <= lu_a_r;
            lu_b_r <= lu_b_r;
        end
    end

    // Result capture: lu_y is sampled once, at the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_y_r     <= 1'b0;
            rsp_id_r    <= '0;
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= (state_r == EXEC);
            if (state_r == EXEC) begin
                rsp_y_r  <= lu_y;
                rsp_id_r <= id_r;
            end else begin
                rsp_y_r  <= rsp_y_r;
                rsp_id_r <= rsp_id_r;
            end
        end
    end

`ifdef LU_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] grant_cnt_r;

    // Saturating accept counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_r <= '0;
        end else if (accept_s && (grant_cnt_r != CNT_MAX)) begin
            grant_cnt_r <= grant_cnt_r + CNT_W'(1);
        end else begin
            grant_cnt_r <= grant_cnt_r;
        end
    end

    assign grant_cnt = grant_cnt_r;
`endif

    assign req_ready = req_ready_s;
    assign lu_a      = lu_a_r;
    assign lu_b      = lu_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_y     = rsp_y_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_lu_arbiter.sv
// Scoreboard testbench for lu_arbiter with an AND cell as the shared logic unit.
module tb_lu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [3:0] req_ready;
    logic       lu_a;
    logic       lu_b;
    logic       lu_y;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic       rsp_y;
    logic       busy;
`ifdef LU_ARB_STATS_EN
    logic [7:0] grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [2:0] sb[$];

    always #5 clk = ~clk;

    assign lu_y = lu_a & lu_b;

    lu_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_y      (lu_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
`ifdef LU_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // Response monitor: every rsp_valid must match the oldest expected entry.
    always @(negedge clk) begin
        logic [2:0] exp_e;
        if (!rst && rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got id=%0d y=%0d, required no response", rsp_id, rsp_y);
            end else begin
                exp_e = sb.pop_front();
                if ({rsp_id, rsp_y} !== exp_e) begin
                    failures++;
                    $display("FAIL rsp_data: got id=%0d y=%0d, required id=%0d y=%0d",
                             rsp_id, rsp_y, exp_e[2:1], exp_e[0]);
                end
            end
        end
    end

    // Drive one request from the IDLE point, wait (bounded) for accept, push the
    // expected response, and return at the following IDLE cycle (+1 after edge).
    task automatic do_op(input logic [3:0] mask, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] exp_w, input bit hold,
                         output logic [3:0] ready_seen, output int waits);
        req_valid = mask;
        req_a     = a;
        req_b     = b;
        waits     = 0;
        #1;
        while (req_ready == 4'd0 && waits < 20) begin
            @(posedge clk);
            #2;
            waits++;
        end
        ready_seen = req_ready;
        if (ready_seen != 4'd0) sb.push_back({exp_w, a[exp_w] & b[exp_w]});
        @(posedge clk);
        #1;
        if (!hold) req_valid = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 4'b1111;
        req_a = 4'b1111;
        req_b = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({req_ready, lu_a, lu_b, rsp_valid, rsp_id, rsp_y, busy} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {req_ready, lu_a, lu_b, rsp_valid, rsp_id, rsp_y, busy});
        end
        req_valid = 4'd0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: got ready=%b busy=%b, required 0000/0", req_ready, busy);
        end
    endtask

    task automatic test_single;
        req_valid = 4'b0100;
        req_a = 4'b0100;
        req_b = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready: got %b, required 0100", req_ready);
        end
        sb.push_back({2'd2, 1'b1});
        @(posedge clk);
        #1;
        req_valid = 4'd0;
        checks++;
        if ({lu_a, lu_b, busy, rsp_valid} !== 4'b1110) begin
            failures++;
            $display("FAIL single_exec: got lu_a/lu_b/busy/rsp_valid=%b, required 1110", {lu_a, lu_b, busy, rsp_valid});
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 1'b1) begin
            failures++;
            $display("FAIL single_resp: got v=%b id=%0d y=%b, required v=1 id=2 y=1", rsp_valid, rsp_id, rsp_y);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_y !== 1'b1) begin
            failures++;
            $display("FAIL single_after: got busy=%b v=%b y=%b, required 0 0 1", busy, rsp_valid, rsp_y);
        end
    endtask

    task automatic test_fairness;
        logic [1:0] order[6];
        logic [3:0] exp_ready;
        logic       exp_busy;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1;
        req_valid = 4'b1111;
        req_a = 4'b1010;
        req_b = 4'b1110;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 18; k++) begin
            if (k % 3 == 0) begin
                exp_ready = 4'b0001 << order[k / 3];
                exp_busy  = 1'b0;
                sb.push_back({order[k / 3], req_a[order[k / 3]] & req_b[order[k / 3]]});
            end else begin
                exp_ready = 4'd0;
                exp_busy  = 1'b1;
            end
            checks++;
            if (req_ready !== exp_ready || busy !== exp_busy) begin
                failures++;
                $display("FAIL fair_cycle%0d: got ready=%b busy=%b, required ready=%b busy=%b",
                         k, req_ready, busy, exp_ready, exp_busy);
            end
            if (k < 17) begin
                @(posedge clk);
                #2;
            end
        end
        req_valid = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL fair_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_wrap;
        logic [3:0] rdy;
        int         w;
        do_op(4'b1000, 4'b1010, 4'b1010, 2'd3, 1'b0, rdy, w);
        checks++;
        if (rdy !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_to3: got %b, required 1000", rdy);
        end
        do_op(4'b1010, 4'b1010, 4'b1010, 2'd1, 1'b1, rdy, w);
        checks++;
        if (rdy !== 4'b0010 || w != 0) begin
            failures++;
            $display("FAIL wrap_first1: got %b wait=%0d, required 0010 wait=0", rdy, w);
        end
        do_op(4'b1010, 4'b1010, 4'b1010, 2'd3, 1'b1, rdy, w);
        checks++;
        if (rdy !== 4'b1000 || w != 0) begin
            failures++;
            $display("FAIL wrap_then3: got %b wait=%0d, required 1000 wait=0", rdy, w);
        end
        do_op(4'b1010, 4'b1010, 4'b1010, 2'd1, 1'b0, rdy, w);
        checks++;
        if (rdy !== 4'b0010 || w != 0) begin
            failures++;
            $display("FAIL wrap_again1: got %b wait=%0d, required 0010 wait=0", rdy, w);
        end
    endtask

    task automatic test_sweep;
        logic [3:0] rdy;
        int         w;
        for (int i = 0; i < 4; i++) begin
            do_op(4'b0001, {3'b000, i[1]}, {3'b000, i[0]}, 2'd0, 1'b0, rdy, w);
            checks++;
            if (rdy !== 4'b0001) begin
                failures++;
                $display("FAIL sweep_ready%0d: got %b, required 0001", i, rdy);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sweep_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_abort;
        req_valid = 4'b0010;
        req_a = 4'b0010;
        req_b = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL abort_ready: got %b, required 0010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 4'd0;
        checks++;
        if (lu_a !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_exec: got lu_a=%b busy=%b, required 1 1", lu_a, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, lu_a, lu_b, rsp_valid, rsp_id, rsp_y, busy} !== 11'd0) begin
            failures++;
            $display("FAIL abort_reset: got %b, required all zero",
                     {req_ready, lu_a, lu_b, rsp_valid, rsp_id, rsp_y, busy});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_norsp%0d: got v=%b busy=%b, required 0 0", k, rsp_valid, busy);
            end
        end
    endtask

`ifdef LU_ARB_STATS_EN
    task automatic test_stats;
        logic [3:0] rdy;
        int         w;
        for (int i = 0; i < 300; i++) begin
            do_op(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, rdy, w);
            if (i == 0 || i == 254 || i == 299) begin
                checks++;
                if (grant_cnt !== ((i == 0) ? 8'd1 : 8'd255)) begin
                    failures++;
                    $display("FAIL stats_cnt%0d: got %0d, required %0d", i + 1, grant_cnt,
                             (i == 0) ? 1 : 255);
                end
            end
        end
        req_valid = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (grant_cnt !== 8'd0) begin
            failures++;
            $display("FAIL stats_reset: got %0d, required 0", grant_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_sweep();
        test_abort();
`ifdef LU_ARB_STATS_EN
        test_stats();
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL final_drain: got %0d pending, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lu_arbiter.md
# lu_arbiter

Round-robin arbiter and sequencer that shares one combinational logic unit (two 1-bit operands, one 1-bit result, e.g. the AND cell) among NUM_REQ requesters. It accepts one operation at a time through a valid/ready handshake, drives the registered operands to the unit, captures the result and returns it with the requester ID. It sits between the top-level pin mapping and the shared logic-unit instance.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- CNT_W, 8, width of the grant statistics counter; used only with LU_ARB_STATS_EN
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  NUM_REQ  operand A, one bit per requester
- req_b  in  NUM_REQ  operand B, one bit per requester
- req_ready  out  NUM_REQ  one-hot accept strobe
- lu_a  out  1  operand A to the shared logic unit (registered)
- lu_b  out  1  operand B to the shared logic unit (registered)
- lu_y  in  1  combinational result from the logic unit
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the result
- rsp_y  out  1  captured result
- busy  out  1  high whenever state is not IDLE
- grant_cnt  out  CNT_W  saturating count of accepts; present only with LU_ARB_STATS_EN

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, no req_valid: stay in IDLE; req_ready is all zero.
- IDLE, any req_valid: pick winner w as the first set bit at or after ptr, searching upward with wrap-around. req_ready[w]=1 combinationally in the same cycle. On the clock edge, latch lu_a<=req_a[w], lu_b<=req_b[w] and id<=w, set ptr<=(w+1) mod NUM_REQ, and go to EXEC.
- EXEC: lu_a and lu_b are stable for the whole cycle. At the end of the cycle, rsp_y<=lu_y and the FSM goes to RESP.
- RESP: rsp_valid=1 and rsp_id=id. Next state is IDLE. No request is accepted in RESP.
- Requesters hold req_valid and operands stable until they see their req_ready. Deasserting req_valid before the grant withdraws the request; this is legal.
- rsp has no backpressure. The consumer must take it in the RESP cycle.
- lu_a, lu_b, rsp_y and rsp_id hold their last values between operations. rsp_valid is asserted only in RESP.
- Reset values: state=IDLE, ptr=0, lu_a=0, lu_b=0, rsp_y=0, rsp_id=0, rsp_valid=0, req_ready=0, busy=0, grant_cnt=0.
- Reset asserted in EXEC or RESP aborts the operation. No rsp_valid is produced for it afterward.

## Timing
- Accept in cycle N. The operands appear on lu_a/lu_b from cycle N+1. rsp_valid is high in cycle N+2.
- Throughput: one operation per 3 cycles. The earliest next accept is cycle N+3.
- lu_y is sampled exactly once, at the end of the EXEC cycle. The logic unit must settle within one cycle.
- req_ready depends combinationally on req_valid and ptr only. There is no path from lu_y to req_ready.

## Configuration
- LU_ARB_STATS_EN defined: the grant_cnt port exists. It increments by 1 on every accept (the cycle where req_ready is non-zero), saturates at 2^CNT_W-1, and is cleared by rst.
- LU_ARB_STATS_EN undefined: there is no grant_cnt port and no counter logic. All other behaviour is identical.

## Structure
- Package lu_arb_pkg holds:
  - the state enum typedef (IDLE, EXEC, RESP);
  - the constant NUM_REQ_MAX=8;
  - the constant ID_W_MAX=3.
- Sub-module rr_picker is purely combinational. It takes req_valid and ptr and produces a one-hot grant plus the winner index. The FSM, the operand and result registers, and the counter stay in lu_arbiter.

## Test plan
- Reset mid-operation: assert rst during EXEC. All outputs go to reset values at once, and no rsp_valid follows after rst is released.
- Single request: requester 2 with a=1, b=1, and lu_y modelled as lu_a&lu_b. req_ready=4'b0100 in cycle N; rsp_valid=1, rsp_id=2, rsp_y=1 in cycle N+2.
- Fairness: all 4 requesters held valid from reset. Grants go 0,1,2,3,0,1, with accepts spaced exactly 3 cycles apart and busy low only in the accept cycles.
- Wrap-around: after a grant to 3 (ptr=0), requesters 1 and 3 are valid. Grant goes to 1, then to 3 (ptr=2), then to 1 again.
- Operand sweep: requester 0 sends (a,b)=00,01,10,11. rsp_y is 0,0,0,1, and each rsp_id=0.
- Stats: with LU_ARB_STATS_EN and CNT_W=8, 300 accepts give grant_cnt=255. After rst, grant_cnt=0. A build without the macro elaborates with no grant_cnt port.
